// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline stall/flush controller for a five-stage in-order core.
// Resolves load-use hazards (one bubble), taken branches (three-stage flush)
// and data-memory waits (full freeze with a timeout into a sticky error state).
// Optional build macro HAZARD_STATS_EN adds saturating stall/flush counters.
module hazard_ctrl #(
    parameter int TIMEOUT = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [4:0] id_rs1,
    input  logic [4:0] id_rs2,
    input  logic       id_uses_rs2,
    input  logic [4:0] ex_rd,
    input  logic       ex_mem_re,
    input  logic       branch_taken,
    input  logic       dmem_req,
    input  logic       dmem_ready,
    output logic       pc_en,
    output logic       if_id_en,
    output logic       id_ex_en,
    output logic       ex_mem_en,
    output logic       if_id_flush,
    output logic       id_ex_flush,
    output logic       ex_mem_flush,
    output logic       mem_wb_flush,
    output logic [1:0] fsm_state,
    output logic       err
`ifdef HAZARD_STATS_EN
    ,
    output logic [15:0] stall_cycles,
    output logic [15:0] flush_events
`endif
);

    typedef enum logic [1:0] {
        RUN  = 2'd0,
        WAIT = 2'd1,
        ERR  = 2'd2
    } state_t;

    // Control vector order:
    // {pc_en, if_id_en, id_ex_en, ex_mem_en, if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush}
    localparam logic [7:0] CTL_NORMAL = 8'b1111_0000;
    localparam logic [7:0] CTL_BRANCH = 8'b1111_1110;
    localparam logic [7:0] CTL_LDUSE  = 8'b0011_0100;
    localparam logic [7:0] CTL_FREEZE = 8'b0000_0001;
    localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

    state_t     state_q, state_d;
    logic [7:0] wait_cnt_q, wait_cnt_d;
    logic       load_use;
    logic [7:0] run_ctl;
    logic [7:0] ctl;

    assign load_use = ex_mem_re && (ex_rd != 5'd0) &&
                      ((ex_rd == id_rs1) || (id_uses_rs2 && (ex_rd == id_rs2)));

    // Normal-flow decision: a taken branch discards the younger instructions,
    // so a load-use hazard seen alongside it is moot.
    always_comb begin
        run_ctl = CTL_NORMAL;
        if (branch_taken) begin
            run_ctl = CTL_BRANCH;
        end else if (load_use) begin
            run_ctl = CTL_LDUSE;
        end
    end

    // Next-state and output decode; memory waits outrank all other events.
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        ctl        = run_ctl;
        err        = 1'b0;
        case (state_q)
            RUN: begin
                if (dmem_req && !dmem_ready) begin
                    ctl        = CTL_FREEZE;
                    state_d    = WAIT;
                    wait_cnt_d = 8'd1;
                end
            end
            WAIT: begin
                if (dmem_ready) begin
                    state_d    = RUN;
                    wait_cnt_d = 8'd0;
                end else begin
                    ctl = CTL_FREEZE;
                    if (wait_cnt_q == TIMEOUT_CNT) begin
                        state_d = ERR;
                    end else begin
                        wait_cnt_d = wait_cnt_q + 8'd1;
                    end
                end
            end
            ERR: begin
                ctl = CTL_FREEZE;
                err = 1'b1;
            end
            default: begin
                state_d    = RUN;
                wait_cnt_d = 8'd0;
            end
        endcase
    end

    assign {pc_en, if_id_en, id_ex_en, ex_mem_en,
            if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush} = ctl;
    assign fsm_state = state_q;

    // State and wait counter registers; reset abandons any stall in progress.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= RUN;
            wait_cnt_q <= 8'd0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

`ifdef HAZARD_STATS_EN
    logic [15:0] stall_cnt_q, stall_cnt_d;
    logic [15:0] flush_cnt_q, flush_cnt_d;

    // Saturating event counters: cycles with the PC held, and branch flushes
    // (if_id_flush is raised only by a taken branch).
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (!pc_en && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
        if (if_id_flush && (flush_cnt_q != 16'hFFFF)) begin
            flush_cnt_d = flush_cnt_q + 16'd1;
        end
    end

    // Counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= 16'd0;
            flush_cnt_q <= 16'd0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cycles = stall_cnt_q;
    assign flush_events = flush_cnt_q;
`endif

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT, default 16, meaning the maximum consecutive data-memory wait cycles before error (range 2..255).
REQ-002 SHALL have port clk  input  1  system clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 SHALL have port id_rs1, id_rs2  input  5 each  source register fields of the instruction in ID.
REQ-005 SHALL have port id_uses_rs2  input  1  ID instruction reads rs2 (R-type, store, branch).
REQ-006 SHALL have port ex_rd  input  5  destination register of the instruction in EX.
REQ-007 SHALL have port ex_mem_re  input  1  instruction in EX is a load.
REQ-008 SHALL have port branch_taken  input  1  MEM-stage branch resolved taken (zero & branch).
REQ-009 SHALL have port dmem_req, dmem_ready  input  1 each  MEM-stage data access pending / completed this cycle.
REQ-010 SHALL have ports pc_en, if_id_en, id_ex_en, ex_mem_en  output  1 each  pipeline register load enables.
REQ-011 SHALL have ports if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush  output  1 each  load a bubble (all-zero controls) instead of data.
REQ-012 SHALL have ports fsm_state  output  2 (RUN=0, WAIT=1, ERR=2), and err  output  1.

Function
REQ-013 SHALL implement FSM states RUN, WAIT and ERR; all stall/flush outputs are combinational from the current state and inputs.
REQ-014 Load-use hazard SHALL be ex_mem_re & (ex_rd != 0) & ((ex_rd == id_rs1) | (id_uses_rs2 & (ex_rd == id_rs2))).
REQ-015 In RUN, with no event, SHALL drive all four enables 1 and all four flushes 0.
REQ-016 In RUN, on load-use hazard only, SHALL drive pc_en=0, if_id_en=0, id_ex_flush=1 for exactly one cycle, inserting one bubble.
REQ-017 In RUN, on branch_taken, SHALL drive all enables 1 and if_id_flush, id_ex_flush, ex_mem_flush 1, discarding three wrong-path instructions; a simultaneous load-use hazard SHALL be ignored.
REQ-018 In RUN, on dmem_req & ~dmem_ready, SHALL drive all enables 0 and all flushes 0 except mem_wb_flush=1; next state WAIT, wait counter loaded with 1. This takes priority over branch and load-use.
REQ-019 In WAIT, while ~dmem_ready, SHALL keep the freeze outputs of REQ-018 and increment the wait counter.
REQ-020 In WAIT, when dmem_ready=1, SHALL apply the RUN rules of REQ-015..REQ-017 in that cycle and return to RUN.
REQ-021 SHALL go to ERR when the wait counter equals TIMEOUT while dmem_ready=0.
REQ-022 In ERR, SHALL drive err=1, all enables 0 and mem_wb_flush=1, and remain there until reset.
REQ-023 The wait counter SHALL be 8 bits wide and SHALL clear on every return to RUN.

Reset
REQ-024 On rst_n=0, SHALL force state RUN, wait counter 0, err=0 and fsm_state=0 immediately, independent of clk.
REQ-025 Reset asserted during WAIT or ERR SHALL abandon the stall; the first cycle after release SHALL follow the RUN rules.

Configuration
REQ-026 With HAZARD_STATS_EN defined, SHALL add outputs stall_cycles[15:0] and flush_events[15:0]; without it, these ports and their logic SHALL be absent.
REQ-027 stall_cycles SHALL increment on each cycle with pc_en=0; flush_events SHALL increment on each branch flush cycle. Both counters saturate at 0xFFFF and clear on reset.

Verification
REQ-028 Case 1: ex_mem_re=1, ex_rd=5, id_rs1=5 for one cycle -> pc_en=0, if_id_en=0, id_ex_flush=1 for one cycle, then all enables 1.
REQ-029 Case 2: ex_mem_re=1, ex_rd=0, id_rs1=0 -> no stall, all enables 1.
REQ-030 Case 3: branch_taken=1 together with a load-use hazard -> if_id_flush, id_ex_flush and ex_mem_flush = 1, pc_en=1, no stall.
REQ-031 Case 4: dmem_req=1, dmem_ready=0 for 3 cycles, then 1 -> 3 frozen cycles with mem_wb_flush=1, fsm_state=1, then RUN.
REQ-032 Case 5: TIMEOUT=4, dmem_ready held 0 -> err=1 and fsm_state=2 after 4 cycles; rst_n pulse -> RUN, err=0.
REQ-033 Case 6 (HAZARD_STATS_EN defined): 2 load-use stalls and 1 branch -> stall_cycles=2, flush_events=1.
